// File: rtl/sched_pkg.sv
// Shared definitions for the round scheduler: FSM state encoding, round
// counter width, default geometry and the step-unit index map.
package sched_pkg;

  localparam int ROUND_W        = 5;
  localparam int NUM_STEPS_DEF  = 5;
  localparam int NUM_ROUNDS_DEF = 24;

  // Step-unit launch order within one round
  localparam int STEP_PERMUTE = 0;
  localparam int STEP_THETA   = 1;
  localparam int STEP_RHO_PI  = 2;
  localparam int STEP_CHI     = 3;
  localparam int STEP_IOTA    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } sched_state_t;

  // Index width for a counter over n items (never zero bits)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_wd_counter.sv
// WAIT-state watchdog for round_scheduler. Only built when SCHED_WATCHDOG_EN
// is defined. Counts cycles while en is high, clears whenever en drops, and
// flags expired on the WD_CYCLES-th consecutive enabled cycle.
`ifdef SCHED_WATCHDOG_EN
module sched_wd_counter
  import sched_pkg::*;
#(
  parameter int WD_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int                CNT_W    = idx_width(WD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running count while waiting; saturates at the limit, clears on leave
  always_ff @(posedge clk) begin
    if (rst || !en)             cnt <= '0;
    else if (cnt != CNT_LAST)   cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CNT_LAST);

endmodule
`endif

// File: rtl/round_scheduler.sv
// round_scheduler: walks NUM_STEPS step units over NUM_ROUNDS rounds with a
// launch/done handshake per unit, toggling the ping-pong buffer after every
// step. Optional WAIT watchdog enabled by defining SCHED_WATCHDOG_EN; without
// it WAIT blocks indefinitely and err stays 0.
module round_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_STEPS  = NUM_STEPS_DEF,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int WD_CYCLES  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_STEPS-1:0] step_done,
  output logic [NUM_STEPS-1:0] step_start,
  output logic                 buf_sel,
  output logic [ROUND_W-1:0]   round_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int                  PTR_W      = idx_width(NUM_STEPS);
  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(NUM_STEPS - 1);
  localparam logic [ROUND_W-1:0]  ROUND_LAST = ROUND_W'(NUM_ROUNDS - 1);

  sched_state_t         state, state_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [ROUND_W-1:0]   round_nxt;
  logic                 buf_nxt;
  logic                 cur_done;
  logic                 wd_trip;

  // Only the unit currently being waited on may complete a step
  assign cur_done = step_done[ptr];

`ifdef SCHED_WATCHDOG_EN
  logic err_q;

  sched_wd_counter #(.WD_CYCLES(WD_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .en      (state == S_WAIT),
    .expired (wd_trip)
  );

  // Sticky watchdog flag; an accepted start begins a clean encode
  always_ff @(posedge clk) begin
    if (rst)                               err_q <= 1'b0;
    else if (state == S_IDLE && start)     err_q <= 1'b0;
    else if (state == S_WAIT && !cur_done && wd_trip) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_wd_cycles;
  assign unused_wd_cycles = (WD_CYCLES > 0);
  assign wd_trip          = 1'b0;
  assign err              = 1'b0;
`endif

  // State, step pointer, round counter and buffer select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      round_idx <= '0;
      buf_sel   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      round_idx <= round_nxt;
      buf_sel   <= buf_nxt;
    end
  end

  // Next-state sequencing: launch, wait for the current unit, advance
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    round_nxt = round_idx;
    buf_nxt   = buf_sel;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LAUNCH;
          ptr_nxt   = '0;
          round_nxt = '0;
          buf_nxt   = 1'b0;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cur_done)     state_nxt = S_ADVANCE;
        else if (wd_trip) state_nxt = S_IDLE;
      end
      S_ADVANCE: begin
        // The unit just finished wrote the other buffer, so swap roles
        buf_nxt = ~buf_sel;
        if (ptr != PTR_LAST) begin
          ptr_nxt   = ptr + 1'b1;
          state_nxt = S_LAUNCH;
        end else if (round_idx != ROUND_LAST) begin
          ptr_nxt   = '0;
          round_nxt = round_idx + 1'b1;
          state_nxt = S_LAUNCH;
        end else begin
          state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // One-hot launch pulse to the unit selected by the step pointer
  always_comb begin
    step_start = '0;
    if (state == S_LAUNCH) step_start[ptr] = 1'b1;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

endmodule
